// File: rtl/qfr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qfr_pkg
// Purpose  : Shared types and constants for the queue frame reader. The
//            DEF_* constants are also used by the queue controller's bench.
// Contents : qfr_state_t  - reader FSM states
//            LEN_W        - width of the length header / remaining counter
//            DEF_DATA_W   - default queue/stream data width
//            DEF_MAX_LEN  - default largest accepted payload length
// Config   : none (QFR_STATS_EN is consumed by queue_frame_reader)
// Revision : 1.0 - initial release
// ============================================================================
package qfr_pkg;

  localparam int LEN_W       = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_MAX_LEN = 64;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_DROP = 2'd2
  } qfr_state_t;

endpackage : qfr_pkg
`default_nettype wire

// File: rtl/qfr_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : qfr_out_stage
// Purpose  : One-entry valid/ready output register for data + last flag.
//            A load always wins; an accept without a load empties the entry.
//            Loading while the entry is being accepted gives full throughput.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_load         - capture i_data/i_last this edge
//            i_data, i_last - byte and end-of-frame flag to capture
//            i_ready        - downstream accept
//            o_data, o_valid, o_last - registered stream outputs
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module qfr_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      // data is left as-is; only the qualifiers drop
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule : qfr_out_stage
`default_nettype wire

// File: rtl/queue_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : queue_frame_reader
// Purpose  : Pops length-prefixed frames (1 header byte = N, then N payload
//            bytes) from a show-ahead byte queue and presents the payload on a
//            registered valid/ready stream with an end-of-frame marker.
//            Oversize frames are drained and flagged with len_err; zero-length
//            frames are silently dropped.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            q_data, q_empty   - queue head word / empty flag (show-ahead)
//            q_deq             - combinational pop request
//            m_data, m_valid, m_last, m_ready - output stream
//            len_err           - 1-cycle pulse on an oversize header
//            busy              - FSM is not waiting for a header
//            frame_cnt, drop_cnt - statistics (QFR_STATS_EN only)
// Config   : `define QFR_STATS_EN adds the frame_cnt/drop_cnt counters.
// Revision : 1.0 - initial release
// ============================================================================
module queue_frame_reader
  import qfr_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] q_data,
  input  logic              q_empty,
  output logic              q_deq,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              len_err,
  output logic              busy
`ifdef QFR_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);

  qfr_state_t       r_state;
  qfr_state_t       w_state_nxt;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] w_remaining_nxt;
  logic             r_len_err;
  logic             w_len_err_nxt;
  logic [LEN_W-1:0] w_len;
  logic             w_rem_is_one;
  logic             w_pop;
  logic             w_load;
  logic             w_load_last;
  logic             w_drop_hdr;

  // --------------------------------------------------------------------------
  // Next-state / pop decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_len_err_nxt   = 1'b0;
    w_pop           = 1'b0;
    w_load          = 1'b0;
    w_load_last     = 1'b0;
    w_drop_hdr      = 1'b0;
    w_len           = q_data[LEN_W-1:0];
    w_rem_is_one    = (r_remaining == c_one);

    case (r_state)
      S_HDR: begin
        w_pop = !q_empty;
        if (w_pop) begin
          if (w_len == '0) begin
            w_drop_hdr = 1'b1;
          end else if (w_len > c_max_len) begin
            w_remaining_nxt = w_len;
            w_len_err_nxt   = 1'b1;
            w_drop_hdr      = 1'b1;
            w_state_nxt     = S_DROP;
          end else begin
            w_remaining_nxt = w_len;
            w_state_nxt     = S_PAY;
          end
        end
      end

      S_PAY: begin
        // Pop only when the output register is free or being emptied now.
        w_pop = !q_empty && (!m_valid || m_ready);
        if (w_pop) begin
          w_load          = 1'b1;
          w_load_last     = w_rem_is_one;
          w_remaining_nxt = r_remaining - c_one;
          if (w_rem_is_one) begin
            w_state_nxt = S_HDR;
          end
        end
      end

      S_DROP: begin
        w_pop = !q_empty;
        if (w_pop) begin
          w_remaining_nxt = r_remaining - c_one;
          if (w_rem_is_one) begin
            w_state_nxt = S_HDR;
          end
        end
      end

      default: begin
        w_state_nxt = S_HDR;
      end
    endcase

    // The queue shares rst, so nothing may be popped during reset.
    if (rst) begin
      w_pop      = 1'b0;
      w_load     = 1'b0;
      w_drop_hdr = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HDR;
      r_remaining <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_len_err   <= w_len_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  qfr_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (q_data),
    .i_last  (w_load_last),
    .i_ready (m_ready),
    .o_data  (m_data),
    .o_valid (m_valid),
    .o_last  (m_last)
  );

  assign q_deq   = w_pop;
  assign len_err = r_len_err;
  assign busy    = (r_state != S_HDR);

`ifdef QFR_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics counters (wrap at 16 bits)
  // --------------------------------------------------------------------------
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (m_valid && m_ready && m_last) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_drop_hdr) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

endmodule : queue_frame_reader
`default_nettype wire

// File: tb/tb_queue_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_frame_reader
// Purpose  : Directed self-checking bench for queue_frame_reader. A simple
//            show-ahead queue model feeds the DUT; a monitor logs every byte
//            accepted by the sink so ordering and counts can be checked.
// Config   : build with QFR_STATS_EN defined to also check the counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_frame_reader;

  logic       clk;
  logic       rst;
  logic [7:0] q_data;
  logic       q_empty;
  logic       q_deq;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       len_err;
  logic       busy;
`ifdef QFR_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
`endif

  queue_frame_reader #(
    .DATA_W  (8),
    .MAX_LEN (64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .q_data  (q_data),
    .q_empty (q_empty),
    .q_deq   (q_deq),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .len_err (len_err)
    ,
    .busy    (busy)
`ifdef QFR_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Queue model and sink monitor
  // --------------------------------------------------------------------------
  logic [7:0] mem [4096];
  int         wr_ptr  = 0;
  int         rd_ptr  = 0;
  int         pop_cnt = 0;
  int         bad_deq = 0;
  int         err_cnt = 0;
  int         acc_cnt = 0;
  logic [7:0] acc_data [256];
  logic       acc_last [256];

  assign q_empty = (rd_ptr == wr_ptr);
  assign q_data  = mem[rd_ptr % 4096];

  always @(posedge clk) begin
    if (q_deq && q_empty) bad_deq <= bad_deq + 1;
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (q_deq && !q_empty) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (!rst && m_valid && m_ready) begin
      acc_data[acc_cnt % 256] <= m_data;
      acc_last[acc_cnt % 256] <= m_last;
      acc_cnt <= acc_cnt + 1;
    end
    if (len_err) err_cnt <= err_cnt + 1;
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 4096] = b;
    wr_ptr++;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (!(q_empty && !busy && !m_valid) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cycles) check("idle_timeout", 32'd1, 32'd0);
  endtask

  int base_pop;
  int base_acc;
  int base_err;
`ifdef QFR_STATS_EN
  logic [15:0] base_frame;
  logic [15:0] base_drop;
`endif

  initial begin
    rst     = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- 1. reset then idle ----
    check("rst_m_data", {24'd0, m_data}, 32'h0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
`ifdef QFR_STATS_EN
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_drop_cnt",  {16'd0, drop_cnt},  32'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {28'd0, q_deq, m_valid, busy, len_err}, 32'd0);
    end

    // ---- 2. single frame, sink always ready ----
    base_pop = pop_cnt;
    push(8'h03); push(8'hA1); push(8'hA2); push(8'hA3);
    @(negedge clk);  // header popped
    check("t2_hdr_valid", {31'd0, m_valid}, 32'd0);
    check("t2_hdr_busy",  {31'd0, busy},    32'd1);
    @(negedge clk);
    check("t2_b1", {22'd0, m_valid, m_last, m_data}, {22'd0, 2'b10, 8'hA1});
    @(negedge clk);
    check("t2_b2", {22'd0, m_valid, m_last, m_data}, {22'd0, 2'b10, 8'hA2});
    @(negedge clk);
    check("t2_b3", {22'd0, m_valid, m_last, m_data}, {22'd0, 2'b11, 8'hA3});
    @(negedge clk);
    check("t2_drain", {30'd0, m_valid, busy}, 32'd0);
    check("t2_pops", pop_cnt - base_pop, 32'd4);

    // ---- 3. sink stalls for 5 cycles after the first byte ----
    base_pop = pop_cnt;
    base_acc = acc_cnt;
    push(8'h03); push(8'hA1); push(8'hA2); push(8'hA3);
    @(negedge clk);
    @(negedge clk);
    check("t3_b1", {22'd0, m_valid, m_last, m_data}, {22'd0, 2'b10, 8'hA1});
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold", {22'd0, m_valid, m_last, m_data}, {22'd0, 2'b10, 8'hA1});
      check("t3_hold_pops", pop_cnt - base_pop, 32'd2);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("t3_b2", {22'd0, m_valid, m_last, m_data}, {22'd0, 2'b10, 8'hA2});
    @(negedge clk);
    check("t3_b3", {22'd0, m_valid, m_last, m_data}, {22'd0, 2'b11, 8'hA3});
    wait_idle(20);
    check("t3_acc_n", acc_cnt - base_acc, 32'd3);
    check("t3_acc0", {23'd0, acc_last[base_acc % 256], acc_data[base_acc % 256]}, {23'd0, 1'b0, 8'hA1});
    check("t3_acc1", {23'd0, acc_last[(base_acc+1) % 256], acc_data[(base_acc+1) % 256]}, {23'd0, 1'b0, 8'hA2});
    check("t3_acc2", {23'd0, acc_last[(base_acc+2) % 256], acc_data[(base_acc+2) % 256]}, {23'd0, 1'b1, 8'hA3});

    // ---- 4. oversize frame drained, then a 1-byte frame ----
    base_pop = pop_cnt;
    base_acc = acc_cnt;
    base_err = err_cnt;
`ifdef QFR_STATS_EN
    base_frame = frame_cnt;
    base_drop  = drop_cnt;
`endif
    push(8'h50);
    for (int i = 0; i < 80; i++) push(8'(i));
    push(8'h01); push(8'h5C);
    @(negedge clk);
    check("t4_len_err_pulse", {30'd0, len_err, busy}, 32'd3);
    @(negedge clk);
    check("t4_len_err_low", {31'd0, len_err}, 32'd0);
    wait_idle(200);
    check("t4_pops", pop_cnt - base_pop, 32'd83);
    check("t4_err_pulses", err_cnt - base_err, 32'd1);
    check("t4_acc_n", acc_cnt - base_acc, 32'd1);
    check("t4_acc0", {23'd0, acc_last[base_acc % 256], acc_data[base_acc % 256]}, {23'd0, 1'b1, 8'h5C});
`ifdef QFR_STATS_EN
    check("t4_drop_cnt",  {16'd0, drop_cnt - base_drop},   32'd1);
    check("t4_frame_cnt", {16'd0, frame_cnt - base_frame}, 32'd1);
`endif

    // ---- 5. zero-length frame dropped, then a 2-byte frame ----
    base_acc = acc_cnt;
`ifdef QFR_STATS_EN
    base_frame = frame_cnt;
    base_drop  = drop_cnt;
`endif
    push(8'h00); push(8'h02); push(8'h11); push(8'h22);
    @(negedge clk);
    check("t5_zero_busy", {30'd0, busy, m_valid}, 32'd0);
    wait_idle(20);
    check("t5_acc_n", acc_cnt - base_acc, 32'd2);
    check("t5_acc0", {23'd0, acc_last[base_acc % 256], acc_data[base_acc % 256]}, {23'd0, 1'b0, 8'h11});
    check("t5_acc1", {23'd0, acc_last[(base_acc+1) % 256], acc_data[(base_acc+1) % 256]}, {23'd0, 1'b1, 8'h22});
`ifdef QFR_STATS_EN
    check("t5_drop_cnt",  {16'd0, drop_cnt - base_drop},   32'd1);
    check("t5_frame_cnt", {16'd0, frame_cnt - base_frame}, 32'd1);
`endif

    // ---- 6. reset mid-frame, then a fresh frame ----
    push(8'h05);
    for (int i = 1; i <= 5; i++) push(8'hB0 + 8'(i));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t6_b2", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'hB2});
    rst = 1'b1;
    #1;
    check("t6_deq_in_rst", {31'd0, q_deq}, 32'd0);
    @(negedge clk);
    check("t6_after_rst", {29'd0, m_valid, m_last, busy}, 32'd0);
    check("t6_deq_in_rst2", {31'd0, q_deq}, 32'd0);
    rst = 1'b0;
    base_acc = acc_cnt;
    push(8'h01); push(8'hEE);
    @(negedge clk);
    @(negedge clk);
    check("t6_fresh", {22'd0, m_valid, m_last, m_data}, {22'd0, 2'b11, 8'hEE});
    wait_idle(20);
    check("t6_acc_n", acc_cnt - base_acc, 32'd1);

    check("no_deq_when_empty", bad_deq, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_queue_frame_reader
`default_nettype wire
